// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations and raises stalls.
// Define HAZARD_SCOREBOARD_FWD_EN to build the bypass-select variant.
module hazard_scoreboard #(
  parameter int IDX_W       = 3,
  parameter int DEPTH       = 3,
  parameter int NUM_SRC     = 2,
  parameter int READY_STAGE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   D_valid,
  input  logic [NUM_SRC*IDX_W-1:0]               D_src_idx,
  input  logic [NUM_SRC-1:0]                     D_src_vld,
  input  logic [IDX_W-1:0]                       D_dst_idx,
  input  logic                                   D_dst_we,
  input  logic                                   pipe_adv,
  input  logic                                   flush,
  output logic                                   D_stall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     D_fwd_sel,
  output logic [DEPTH*IDX_W-1:0]                 stage_dst_idx,
  output logic [DEPTH-1:0]                       stage_we,
  output logic [CNT_W-1:0]                       stall_cnt
);

  localparam int FSEL_W = $clog2(DEPTH+1);

`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic [DEPTH-1:0][IDX_W-1:0] dst_q, dst_d;
  logic [DEPTH-1:0]            we_q, we_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [NUM_SRC-1:0]          src_stall;
  logic [NUM_SRC*FSEL_W-1:0]   fwd_raw;

  // Oldest-to-youngest scan so the youngest matching stage decides.
  always_comb begin
    src_stall = '0;
    fwd_raw   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = DEPTH-1; s >= 0; s--) begin
        if (D_valid && D_src_vld[i] && we_q[s] &&
            (D_src_idx[i*IDX_W +: IDX_W] == dst_q[s])) begin
          src_stall[i] = !FwdEn || (s < READY_STAGE);
          fwd_raw[i*FSEL_W +: FSEL_W] = FSEL_W'(s + 1);
        end
      end
    end
  end

  assign D_stall   = |src_stall;
  assign D_fwd_sel = (D_stall || !FwdEn) ? '0 : fwd_raw;

  always_comb begin
    dst_d = dst_q;
    we_d  = we_q;
    if (flush) begin
      // Oldest stage is committing, so it survives the squash.
      for (int s = 0; s < DEPTH-1; s++) we_d[s] = 1'b0;
    end else if (pipe_adv) begin
      for (int s = 1; s < DEPTH; s++) begin
        dst_d[s] = dst_q[s-1];
        we_d[s]  = we_q[s-1];
      end
      dst_d[0] = D_dst_idx;
      we_d[0]  = D_valid & D_dst_we & ~D_stall;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (D_stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q <= '0;
      we_q  <= '0;
      cnt_q <= '0;
    end else begin
      dst_q <= dst_d;
      we_q  <= we_d;
      cnt_q <= cnt_d;
    end
  end

  assign stage_dst_idx = dst_q;
  assign stage_we      = we_q;
  assign stall_cnt     = cnt_q;

endmodule
